subroutine_ctrl: RTL and testbench
==================================

# subroutine_ctrl

Sequencer that drives the processor's hardware return stack on behalf of the control unit. It converts single-cycle call, return, interrupt-entry and return-from-interrupt requests into correctly ordered push/pop strobes. It captures popped words back into PC and flag restore outputs. It tracks stack depth and refuses any operation that would overflow or underflow. It sits between the control unit/datapath and the return stack's `we_stack` / `s_pushpop` / `data_in` / `data_out` pins.

## Interface
- WIDTH, 10, stack word / PC width
- NWORDS, 16, stack capacity in words; must equal the return stack's capacity
- FLAGW, 2, width of the saved flag field; FLAGW ≤ WIDTH
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; same net that resets the return stack
- call  in  1  request: push `pc_ret`
- ret  in  1  request: pop into PC
- irq  in  1  request: push `pc_ret`, then push flags
- reti  in  1  request: pop flags, then pop PC
- pc_ret  in  WIDTH  return address from datapath (PC+1)
- flags_in  in  FLAGW  current flags, saved on `irq`
- stk_data_out  in  WIDTH  return stack read data
- we_stack  out  1  stack strobe, one cycle per push/pop
- s_pushpop  out  1  0 = push, 1 = pop; valid when `we_stack`=1, 0 otherwise
- stk_data_in  out  WIDTH  word to push
- pc_out  out  WIDTH  restored PC, held until next load
- pc_load  out  1  one-cycle pulse: `pc_out` valid
- flags_out  out  FLAGW  restored flags, held until next load
- flags_load  out  1  one-cycle pulse: `flags_out` valid
- busy  out  1  sequence in progress; requests ignored
- depth  out  $clog2(NWORDS)+1  words currently on stack
- full, empty  out  1 each  `depth`==NWORDS / `depth`==0
- err  out  1  sticky: a refused over/underflow request occurred; cleared only by reset

## Operation
- States: IDLE, PUSH_PC, PUSH_FL, POP_FL, POP_PC, LOAD.
- Requests are sampled only at a rising edge in IDLE.
- If several requests are high together, priority is irq > reti > call > ret. Lower-priority requests are dropped, not queued. The requester holds its request until it sees it serviced.
- call: check `depth` ≤ NWORDS-1, latch `pc_ret`, go to PUSH_PC, then IDLE. Depth +1.
- irq: check `depth` ≤ NWORDS-2, latch `pc_ret` and `flags_in`.
  - PUSH_PC pushes the PC.
  - PUSH_FL pushes the flags zero-extended to WIDTH.
  - Then IDLE. Depth +2.
- ret: check `depth` ≥ 1, then POP_PC, then LOAD, then IDLE. Depth -1.
- reti: check `depth` ≥ 2, then POP_FL, POP_PC, LOAD, IDLE.
  - POP_FL captures `stk_data_out[FLAGW-1:0]`.
  - Depth -2.
- Stack outputs are decoded from state (Moore):
  - PUSH_*: `we_stack`=1, `s_pushpop`=0, `stk_data_in` = latched word.
  - POP_*: `we_stack`=1, `s_pushpop`=1.
  - All other states: `we_stack`=0, `stk_data_in`=0.
- Pops: `stk_data_out` is sampled at the rising edge that ends the POP cycle.
- Refused request (failed depth check):
  - `err` is set.
  - No stack strobe, no load pulse, no depth change.
  - FSM stays in IDLE.
- `busy` = 1 in every state except IDLE.
- In LOAD:
  - `pc_load`=1 for one cycle.
  - `flags_load`=1 for the same cycle only when the sequence was reti.
- `depth` updates at the rising edge ending each push/pop cycle.

## Timing
- Reset, asynchronous, effective immediately:
  - state = IDLE.
  - `depth`=0, `empty`=1.
  - All other outputs 0, including `pc_out` and `flags_out`.
- Reset mid-sequence aborts the sequence with no further strobes. The stack's own pointer resets on the same net, so the two stay consistent.
- Request sampled at edge E0:
  - call: PUSH_PC during E0–E1, busy low from E1.
  - irq: pushes during E0–E1 and E1–E2.
  - ret: pop during E0–E1, `pc_load` during E1–E2.
  - reti: pops during E0–E1 and E1–E2, `pc_load` and `flags_load` during E2–E3.
- Next request can be accepted at the edge ending LOAD or the last push cycle.
- `full`, `empty` and `depth` are registered and change at the same edge.

## Test plan
- Reset with all requests low:
  - `depth`=0, `empty`=1, `full`=0, `err`=0, `we_stack`=0.
  - Assert reset mid-PUSH_FL: outputs return to 0 immediately.
- call with `pc_ret`=0x05A, then ret:
  - One cycle `we_stack`=1, `s_pushpop`=0, `stk_data_in`=0x05A, depth 1.
  - Then one pop cycle, then `pc_load` pulse with `pc_out`=0x05A, depth 0.
- irq with `pc_ret`=0x123, `flags_in`=2'b10, then reti:
  - Pushes 0x123 then 0x002.
  - reti gives `pc_out`=0x123 and `flags_out`=2'b10, both loads in the same cycle, depth back to 0.
- Fill:
  - 16 calls with PCs 0..15 give `full`=1 and depth 16.
  - A 17th call sets `err`=1 with no strobe.
  - 16 rets return 15..0 in order; `empty`=1 at the end.
- Underflow:
  - ret at depth 0 sets `err`, with no strobe and no `pc_load`.
  - reti at depth 1 is refused.
  - irq at depth 15 is refused and depth stays 15.
- irq and call asserted together with call held: irq sequence runs first, then call is accepted after busy drops; final depth 3.

Source files
------------

// File: rtl/subroutine_ctrl.sv
// Return-stack sequencer: turns call/ret/irq/reti requests into push/pop strobes and PC/flag restores.
// Latency: call 1 cycle, irq 2, ret 2 (pop+load), reti 3; requests ignored (busy) until back in IDLE.
module subroutine_ctrl #(
    parameter int WIDTH  = 10,
    parameter int NWORDS = 16,
    parameter int FLAGW  = 2,
    localparam int DW    = $clog2(NWORDS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call,
    input  logic             ret,
    input  logic             irq,
    input  logic             reti,
    input  logic [WIDTH-1:0] pc_ret,
    input  logic [FLAGW-1:0] flags_in,
    input  logic [WIDTH-1:0] stk_data_out,
    output logic             we_stack,
    output logic             s_pushpop,
    output logic [WIDTH-1:0] stk_data_in,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_load,
    output logic [FLAGW-1:0] flags_out,
    output logic             flags_load,
    output logic             busy,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, PUSH_PC, PUSH_FL, POP_FL, POP_PC, LOAD} state_t;

    localparam logic [DW-1:0] CAP = DW'(NWORDS);

    state_t           state, state_nxt;
    logic [DW-1:0]    depth_nxt;
    logic [WIDTH-1:0] pc_lat;
    logic [FLAGW-1:0] fl_lat;
    logic             seq_fl, seq_fl_nxt;
    logic             lat_en, err_set;

    always_comb begin
        state_nxt  = state;
        depth_nxt  = depth;
        seq_fl_nxt = seq_fl;
        lat_en     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                // Only the highest-priority request is considered; a refused one does not fall through.
                if (irq) begin
                    if ((depth + DW'(1)) < CAP) begin
                        state_nxt  = PUSH_PC;
                        seq_fl_nxt = 1'b1;
                        lat_en     = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (reti) begin
                    if (depth > DW'(1)) begin
                        state_nxt  = POP_FL;
                        seq_fl_nxt = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (call) begin
                    if (depth < CAP) begin
                        state_nxt  = PUSH_PC;
                        seq_fl_nxt = 1'b0;
                        lat_en     = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (ret) begin
                    if (depth != '0) begin
                        state_nxt  = POP_PC;
                        seq_fl_nxt = 1'b0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            PUSH_PC: begin
                depth_nxt = depth + DW'(1);
                state_nxt = seq_fl ? PUSH_FL : IDLE;
            end
            PUSH_FL: begin
                depth_nxt = depth + DW'(1);
                state_nxt = IDLE;
            end
            POP_FL: begin
                depth_nxt = depth - DW'(1);
                state_nxt = POP_PC;
            end
            POP_PC: begin
                depth_nxt = depth - DW'(1);
                state_nxt = LOAD;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            depth     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            err       <= 1'b0;
            seq_fl    <= 1'b0;
            pc_lat    <= '0;
            fl_lat    <= '0;
            pc_out    <= '0;
            flags_out <= '0;
        end else begin
            state  <= state_nxt;
            depth  <= depth_nxt;
            full   <= (depth_nxt == CAP);
            empty  <= (depth_nxt == '0);
            seq_fl <= seq_fl_nxt;
            if (err_set) err <= 1'b1;
            if (lat_en) begin
                pc_lat <= pc_ret;
                fl_lat <= flags_in;
            end
            // Pop data is taken at the edge that closes the pop cycle.
            if (state == POP_FL) flags_out <= stk_data_out[FLAGW-1:0];
            if (state == POP_PC) pc_out    <= stk_data_out;
        end
    end

    always_comb begin
        we_stack    = 1'b0;
        s_pushpop   = 1'b0;
        stk_data_in = '0;
        pc_load     = 1'b0;
        flags_load  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            PUSH_PC: begin
                we_stack    = 1'b1;
                stk_data_in = pc_lat;
            end
            PUSH_FL: begin
                we_stack    = 1'b1;
                stk_data_in = WIDTH'(fl_lat);
            end
            POP_FL, POP_PC: begin
                we_stack  = 1'b1;
                s_pushpop = 1'b1;
            end
            LOAD: begin
                pc_load    = 1'b1;
                flags_load = seq_fl;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_subroutine_ctrl.sv
// Directed bench for subroutine_ctrl with a behavioural return stack on the same reset net.
module tb_subroutine_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       call = 1'b0, ret = 1'b0, irq = 1'b0, reti = 1'b0;
    logic [9:0] pc_ret = '0;
    logic [1:0] flags_in = '0;
    logic [9:0] stk_data_out;
    logic       we_stack, s_pushpop, pc_load, flags_load, busy, full, empty, err;
    logic [9:0] stk_data_in, pc_out;
    logic [1:0] flags_out;
    logic [4:0] depth;

    int checks = 0;
    int failures = 0;

    subroutine_ctrl dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .irq(irq), .reti(reti),
        .pc_ret(pc_ret), .flags_in(flags_in), .stk_data_out(stk_data_out),
        .we_stack(we_stack), .s_pushpop(s_pushpop), .stk_data_in(stk_data_in),
        .pc_out(pc_out), .pc_load(pc_load), .flags_out(flags_out), .flags_load(flags_load),
        .busy(busy), .depth(depth), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    // Return stack: push writes at the edge, top-of-stack is visible combinationally.
    logic [9:0] mem [16];
    logic [4:0] sp;
    always @(posedge clk or posedge reset) begin
        if (reset) sp <= '0;
        else if (we_stack) begin
            if (!s_pushpop) begin
                mem[sp[3:0]] <= stk_data_in;
                sp <= sp + 5'd1;
            end else begin
                sp <= sp - 5'd1;
            end
        end
    end
    assign stk_data_out = (sp != 0) ? mem[sp[3:0] - 4'd1] : 10'h000;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Raise the requests for one sampling edge; returns at the negedge inside the first sequence cycle.
    task automatic req(input logic c, input logic r, input logic i, input logic ri);
        @(negedge clk);
        call = c; ret = r; irq = i; reti = ri;
        @(negedge clk);
        call = 1'b0; ret = 1'b0; irq = 1'b0; reti = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (depth !== 5'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if ({we_stack, busy, pc_load} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {we_stack, busy, pc_load}); end
    endtask

    task automatic test_call_ret();
        pc_ret = 10'h05A;
        req(1, 0, 0, 0);
        checks++; if ({we_stack, s_pushpop, busy} !== 3'b101) begin failures++; $display("FAIL call_push got=%b exp=101", {we_stack, s_pushpop, busy}); end
        checks++; if (stk_data_in !== 10'h05A) begin failures++; $display("FAIL call_data got=%h exp=05a", stk_data_in); end
        @(negedge clk);
        checks++; if ({we_stack, busy, depth} !== {2'b00, 5'd1}) begin failures++; $display("FAIL call_done got we=%b busy=%b depth=%0d exp 0 0 1", we_stack, busy, depth); end
        pc_ret = 10'h3FF;
        req(0, 1, 0, 0);
        checks++; if ({we_stack, s_pushpop, pc_load} !== 3'b110) begin failures++; $display("FAIL ret_pop got=%b exp=110", {we_stack, s_pushpop, pc_load}); end
        @(negedge clk);
        checks++; if ({pc_load, flags_load, we_stack} !== 3'b100) begin failures++; $display("FAIL ret_load got=%b exp=100", {pc_load, flags_load, we_stack}); end
        checks++; if (pc_out !== 10'h05A) begin failures++; $display("FAIL ret_pc got=%h exp=05a", pc_out); end
        checks++; if ({depth, empty} !== {5'd0, 1'b1}) begin failures++; $display("FAIL ret_depth got depth=%0d empty=%b exp 0 1", depth, empty); end
        @(negedge clk);
        checks++; if ({pc_load, busy} !== 2'b00) begin failures++; $display("FAIL ret_idle got=%b exp=00", {pc_load, busy}); end
    endtask

    task automatic test_irq_reti();
        pc_ret = 10'h123; flags_in = 2'b10;
        req(0, 0, 1, 0);
        checks++; if ({we_stack, s_pushpop, stk_data_in} !== {2'b10, 10'h123}) begin failures++; $display("FAIL irq_push_pc got we=%b pp=%b d=%h exp 1 0 123", we_stack, s_pushpop, stk_data_in); end
        @(negedge clk);
        checks++; if ({we_stack, s_pushpop, stk_data_in} !== {2'b10, 10'h002}) begin failures++; $display("FAIL irq_push_fl got we=%b pp=%b d=%h exp 1 0 002", we_stack, s_pushpop, stk_data_in); end
        @(negedge clk);
        checks++; if ({busy, we_stack, depth} !== {2'b00, 5'd2}) begin failures++; $display("FAIL irq_done got busy=%b we=%b depth=%0d exp 0 0 2", busy, we_stack, depth); end
        flags_in = 2'b00;
        req(0, 0, 0, 1);
        checks++; if ({we_stack, s_pushpop} !== 2'b11) begin failures++; $display("FAIL reti_pop1 got=%b exp=11", {we_stack, s_pushpop}); end
        @(negedge clk);
        checks++; if ({we_stack, s_pushpop, pc_load, depth} !== {3'b110, 5'd1}) begin failures++; $display("FAIL reti_pop2 got=%b depth=%0d exp 110 1", {we_stack, s_pushpop, pc_load}, depth); end
        @(negedge clk);
        checks++; if ({pc_load, flags_load, we_stack} !== 3'b110) begin failures++; $display("FAIL reti_load got=%b exp=110", {pc_load, flags_load, we_stack}); end
        checks++; if ({pc_out, flags_out} !== {10'h123, 2'b10}) begin failures++; $display("FAIL reti_vals got pc=%h fl=%b exp 123 10", pc_out, flags_out); end
        checks++; if ({depth, empty} !== {5'd0, 1'b1}) begin failures++; $display("FAIL reti_depth got depth=%0d empty=%b exp 0 1", depth, empty); end
    endtask

    task automatic test_reset_mid();
        pc_ret = 10'h155; flags_in = 2'b11;
        req(0, 0, 1, 0);
        @(negedge clk);
        checks++; if ({we_stack, stk_data_in} !== {1'b1, 10'h003}) begin failures++; $display("FAIL mid_pushfl got we=%b d=%h exp 1 003", we_stack, stk_data_in); end
        reset = 1'b1;
        #1;
        checks++; if ({we_stack, busy, stk_data_in} !== {2'b00, 10'h000}) begin failures++; $display("FAIL mid_reset_strobe got we=%b busy=%b d=%h exp 0 0 000", we_stack, busy, stk_data_in); end
        checks++; if ({depth, empty, full} !== {5'd0, 2'b10}) begin failures++; $display("FAIL mid_reset_depth got depth=%0d empty=%b full=%b exp 0 1 0", depth, empty, full); end
        checks++; if ({pc_out, flags_out} !== 12'h000) begin failures++; $display("FAIL mid_reset_regs got pc=%h fl=%b exp 000 00", pc_out, flags_out); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pc_ret = 10'(i);
            req(1, 0, 0, 0);
            @(negedge clk);
        end
        checks++; if ({depth, full, empty} !== {5'd16, 2'b10}) begin failures++; $display("FAIL fill_full got depth=%0d full=%b empty=%b exp 16 1 0", depth, full, empty); end
        pc_ret = 10'h2AA;
        req(1, 0, 0, 0);
        checks++; if ({we_stack, busy, err, depth} !== {3'b001, 5'd16}) begin failures++; $display("FAIL fill_overflow got we=%b busy=%b err=%b depth=%0d exp 0 0 1 16", we_stack, busy, err, depth); end
        for (int i = 0; i < 16; i++) begin
            req(0, 1, 0, 0);
            @(negedge clk);
            checks++; if ({pc_load, pc_out} !== {1'b1, 10'(15 - i)}) begin failures++; $display("FAIL fill_ret%0d got load=%b pc=%h exp 1 %h", i, pc_load, pc_out, 10'(15 - i)); end
        end
        @(negedge clk);
        checks++; if ({depth, empty, full} !== {5'd0, 2'b10}) begin failures++; $display("FAIL fill_empty got depth=%0d empty=%b full=%b exp 0 1 0", depth, empty, full); end
    endtask

    task automatic test_underflow();
        do_reset();
        req(0, 1, 0, 0);
        checks++; if ({we_stack, busy, err} !== 3'b001) begin failures++; $display("FAIL uf_ret got we=%b busy=%b err=%b exp 0 0 1", we_stack, busy, err); end
        @(negedge clk);
        checks++; if ({pc_load, we_stack, depth} !== {2'b00, 5'd0}) begin failures++; $display("FAIL uf_ret_load got load=%b we=%b depth=%0d exp 0 0 0", pc_load, we_stack, depth); end
        do_reset();
        pc_ret = 10'h011;
        req(1, 0, 0, 0);
        @(negedge clk);
        req(0, 0, 0, 1);
        checks++; if ({we_stack, busy, err, depth} !== {3'b001, 5'd1}) begin failures++; $display("FAIL uf_reti got we=%b busy=%b err=%b depth=%0d exp 0 0 1 1", we_stack, busy, err, depth); end
        do_reset();
        for (int i = 0; i < 15; i++) begin
            pc_ret = 10'(i + 100);
            req(1, 0, 0, 0);
            @(negedge clk);
        end
        checks++; if ({depth, err} !== {5'd15, 1'b0}) begin failures++; $display("FAIL of_pre got depth=%0d err=%b exp 15 0", depth, err); end
        req(0, 0, 1, 0);
        checks++; if ({we_stack, busy, err} !== 3'b001) begin failures++; $display("FAIL of_irq got we=%b busy=%b err=%b exp 0 0 1", we_stack, busy, err); end
        @(negedge clk);
        checks++; if ({we_stack, depth} !== {1'b0, 5'd15}) begin failures++; $display("FAIL of_irq_depth got we=%b depth=%0d exp 0 15", we_stack, depth); end
    endtask

    task automatic test_priority();
        logic [9:0] pushes[$];
        bit done;
        do_reset();
        pc_ret = 10'h200; flags_in = 2'b01;
        @(negedge clk);
        irq = 1'b1; call = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            irq = 1'b0;
            if (we_stack && !s_pushpop) pushes.push_back(stk_data_in);
            if (pushes.size() >= 3) begin
                call = 1'b0;
                if (!busy) done = 1'b1;
            end
        end
        call = 1'b0;
        checks++; if (!done) begin failures++; $display("FAIL prio_timeout got pushes=%0d exp 3", pushes.size()); end
        checks++; if (pushes.size() != 3 || pushes[0] !== 10'h200 || pushes[1] !== 10'h001 || pushes[2] !== 10'h200)
            begin failures++; $display("FAIL prio_order got n=%0d seq=%p exp 200 001 200", pushes.size(), pushes); end
        checks++; if ({depth, err} !== {5'd3, 1'b0}) begin failures++; $display("FAIL prio_depth got depth=%0d err=%b exp 3 0", depth, err); end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_irq_reti();
        test_reset_mid();
        test_fill();
        test_underflow();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
